// File: rtl/systolic_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// systolic_sequencer_pkg
// Shared definitions for the lvg dripper / systolic array control path:
// FSM state encoding (3-bit binary) and the default matrix geometry that the
// dripper and PE array are built with.
// Ports: none (package).
// -----------------------------------------------------------------------------
package systolic_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRIP   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } seq_state_e;

  localparam int DEFAULT_N         = 4;
  localparam int DEFAULT_DRAIN_CYC = 4;
  localparam int DEFAULT_CNT_W     = 6;

  // A zero-cycle drain still needs a 1-bit register to exist.
  function automatic int drain_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Control FSM for one NxN matrix pass: load the dripper, step it through the
// skew window 1..2N-1, let the PE array drain for DRAIN_CYC cycles, then offer
// the result with a valid/ready handshake and pulse done.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request a pass (only honoured in IDLE)
//   abort        in   synchronous cancel back to IDLE, no done
//   result_ready in   consumer accepts the result
//   load         out  dripper load strobe
//   count        out  dripper step index (0..2N)
//   acc_clear    out  clear PE accumulators (with load)
//   array_en     out  PE array advance enable
//   busy         out  high whenever the FSM is not IDLE
//   result_valid out  PE outputs final, held until accepted
//   done         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int DRAIN_CYC = DEFAULT_DRAIN_CYC,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             result_ready,
  output logic             load,
  output logic [CNT_W-1:0] count,
  output logic             acc_clear,
  output logic             array_en,
  output logic             busy,
  output logic             result_valid,
  output logic             done
);

  localparam int DRAIN_W = drain_width(DRAIN_CYC);

  localparam logic [CNT_W-1:0]   LAST_STEP  = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0]   DRAIN_STEP = CNT_W'(2 * N);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC);

  seq_state_e         state, state_next;
  logic [CNT_W-1:0]   count_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_next;
  logic               done_next;

  // Next-state and counter logic. Every output is registered, so the values
  // computed here are what the outputs will show after the coming edge.
  always_comb begin
    state_next = state;
    count_next = count;
    drain_next = drain_cnt;
    done_next  = 1'b0;

    unique case (state)
      IDLE: begin
        count_next = '0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        state_next = DRIP;
        count_next = CNT_W'(1);
      end
      DRIP: begin
        if (count == LAST_STEP) begin
          // The dripper emits zeros once count reaches 2N, so parking count
          // there keeps the array fed with zeros while it drains.
          if (DRAIN_CYC == 0) begin
            state_next = RESULT;
            count_next = '0;
          end else begin
            state_next = DRAIN;
            count_next = DRAIN_STEP;
            drain_next = DRAIN_W'(1);
          end
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = RESULT;
          count_next = '0;
          drain_next = '0;
        end else begin
          drain_next = drain_cnt + DRAIN_W'(1);
        end
      end
      RESULT: begin
        count_next = '0;
        if (result_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        drain_next = '0;
      end
    endcase

    // Abort beats every other transition, including start and the handshake.
    if (abort) begin
      state_next = IDLE;
      count_next = '0;
      drain_next = '0;
      done_next  = 1'b0;
    end
  end

  // State, counters and the registered copies of the decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      drain_cnt    <= '0;
      load         <= 1'b0;
      acc_clear    <= 1'b0;
      array_en     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      drain_cnt    <= drain_next;
      load         <= (state_next == LOAD);
      acc_clear    <= (state_next == LOAD);
      array_en     <= (state_next == DRIP) || (state_next == DRAIN);
      busy         <= (state_next != IDLE);
      result_valid <= (state_next == RESULT);
      done         <= done_next;
    end
  end

endmodule
